// File: rtl/rlbp_cap_pkg.sv
// Shared definitions for the RLBP serial capture block: register offsets,
// STATUS/CTRL bit positions and the packed STATUS word.
package rlbp_cap_pkg;

  // Register offsets within the 16-byte decode window
  localparam logic [3:0] OFS_DATA   = 4'h0;
  localparam logic [3:0] OFS_STATUS = 4'h4;
  localparam logic [3:0] OFS_CTRL   = 4'h8;

  // STATUS bit positions
  localparam int ST_EMPTY     = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_OVF       = 2;
  localparam int ST_UDF       = 3;
  localparam int ST_COUNT_LSB = 8;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_CLR     = 1;
  localparam int CTRL_THR_LSB = 8;

  localparam int THR_W       = 6;
  localparam int CNT_FIELD_W = 7;

  typedef struct packed {
    logic [16:0]            rsvd_hi;
    logic [CNT_FIELD_W-1:0] count;
    logic [3:0]             rsvd_lo;
    logic                   udf;
    logic                   ovf;
    logic                   full;
    logic                   empty;
  } status_t;

  // CTRL read-back word; clr always reads 0
  function automatic logic [31:0] ctrl_word(input logic en, input logic [THR_W-1:0] thr);
    return {18'b0, thr, 7'b0, en};
  endfunction

endpackage

// File: rtl/rlbp_cap_fifo.sv
// Synchronous FIFO for captured codes. Pointers carry one extra wrap bit so
// full/empty come from an MSB compare. flush_i empties the FIFO and discards
// any push/pop presented in the same cycle.
//
// Handshake: push_i is a valid strobe with no ready; a push while full (and
// not popped in the same cycle) is dropped and flagged on drop_o. pop_i while
// empty is ignored.
module rlbp_cap_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  input  logic              flush_i,
  output logic [DATA_W-1:0] head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o,
  output logic              drop_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign count_o = wr_ptr_q - rd_ptr_q;
  assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

  // A push into a full FIFO still lands when a pop frees the slot that cycle
  assign do_pop  = pop_i & ~empty_o & ~flush_i;
  assign do_push = push_i & (~full_o | do_pop) & ~flush_i;
  assign drop_o  = push_i & full_o & ~do_pop & ~flush_i;

  // Next pointer values
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  // Pointer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage write; contents are don't-care until pointed at
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/rlbp_serial_capture.sv
// RLBP serial capture: deserializes the RLBP bit stream into DATA_W-bit codes,
// buffers them in a FIFO and exposes DATA/STATUS/CTRL as a Wishbone slave.
// Optional build macro RLBP_CAP_IRQ_EN enables the fill-threshold interrupt
// and the CTRL.thr field; without it irq_o is 0 and thr reads 0.
module rlbp_serial_capture
  import rlbp_cap_pkg::*;
#(
  parameter int          DATA_W     = 8,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [31:0] BASE_ADR   = 32'h3000_0100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_data_i,
  input  logic        s_bit_en_i,
  input  logic        s_sync_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        irq_o
);

  localparam int CW = $clog2(DATA_W);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Deserializer state
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              word_done;
  logic              push_q;
  logic [DATA_W-1:0] word_q;

  // Registers and flags
  logic              en_q;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic [THR_W-1:0]  thr;

  // Wishbone
  logic              ack_q;
  logic [31:0]       dat_q;
  logic              hit, acc;
  logic [3:0]        ofs;
  logic              data_rd, status_wr, ctrl_wr, clr;
  logic [31:0]       rd_word;
  status_t           status;

  // FIFO
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_full, fifo_empty, fifo_drop;
  logic [AW:0]       fifo_count;

  // Wishbone decode: one access per two clocks since ack_q blocks re-acceptance
  assign hit       = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign acc       = hit & ~ack_q;
  assign ofs       = wbs_adr_i[3:0];
  assign data_rd   = acc & ~wbs_we_i & (ofs == OFS_DATA);
  assign status_wr = acc & wbs_we_i & wbs_sel_i[0] & (ofs == OFS_STATUS);
  assign ctrl_wr   = acc & wbs_we_i & wbs_sel_i[0] & (ofs == OFS_CTRL);
  assign clr       = ctrl_wr & wbs_dat_i[CTRL_CLR];

  // Deserializer next state: shift on bit enable, resync or clr restart the word
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    word_done = 1'b0;
    if (en_q) begin
      if (s_bit_en_i) shreg_d = {shreg_q[DATA_W-2:0], s_data_i};
      if (s_sync_i) begin
        bit_cnt_d = s_bit_en_i ? CW'(1) : '0;
      end else if (s_bit_en_i) begin
        if (bit_cnt_q == CW'(DATA_W - 1)) begin
          bit_cnt_d = '0;
          word_done = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
      end
    end
    if (clr) bit_cnt_d = '0;
  end

  // Deserializer registers; a completed word is pushed on the following clock
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      push_q    <= 1'b0;
      word_q    <= '0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      push_q    <= word_done & ~clr;
      if (word_done) word_q <= shreg_d;
    end
  end

  rlbp_cap_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push_q),
    .push_data_i (word_q),
    .pop_i       (data_rd),
    .flush_i     (clr),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .drop_o      (fifo_drop)
  );

  // Sticky flags: events set, write-1 clears, clr wipes both
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (status_wr && wbs_dat_i[ST_OVF]) ovf_d = 1'b0;
    if (status_wr && wbs_dat_i[ST_UDF]) udf_d = 1'b0;
    if (fifo_drop)                      ovf_d = 1'b1;
    if (data_rd && fifo_empty)          udf_d = 1'b1;
    if (clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
  end

  // Control and flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      en_q  <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (ctrl_wr) en_q <= wbs_dat_i[CTRL_EN];
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

`ifdef RLBP_CAP_IRQ_EN
  logic [THR_W-1:0] thr_q;
  logic             irq_q;

  // Threshold register and registered fill/overflow interrupt
  always_ff @(posedge clk) begin
    if (rst) begin
      thr_q <= '0;
      irq_q <= 1'b0;
    end else begin
      if (ctrl_wr) thr_q <= wbs_dat_i[CTRL_THR_LSB +: THR_W];
      irq_q <= (en_q && (8'(fifo_count) >= 8'(thr_q)) && (thr_q != '0)) || ovf_q;
    end
  end

  assign thr   = thr_q;
  assign irq_o = irq_q;
`else
  assign thr   = '0;
  assign irq_o = 1'b0;
`endif

  // Read data mux; empty DATA reads and unmapped offsets return 0
  always_comb begin
    status       = '0;
    status.count = CNT_FIELD_W'(fifo_count);
    status.udf   = udf_q;
    status.ovf   = ovf_q;
    status.full  = fifo_full;
    status.empty = fifo_empty;
    rd_word      = '0;
    case (ofs)
      OFS_DATA:   if (!fifo_empty) rd_word = 32'(fifo_head);
      OFS_STATUS: rd_word = status;
      OFS_CTRL:   rd_word = ctrl_word(en_q, thr);
      default:    rd_word = '0;
    endcase
  end

  // Ack and read data registered together; data is 0 whenever ack is low
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc && !wbs_we_i) ? rd_word : '0;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;

  logic unused_ok;
  assign unused_ok = ^{wbs_sel_i[3:1], wbs_dat_i};

endmodule
